// File: rtl/aes_encr_seq.sv
// AES-128 iterative encryptor: one round per clock with on-the-fly key expansion.
// A block is accepted in IDLE, runs ten rounds, then holds the ciphertext in DONE until it is taken.
module aes_encr_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 4;
  localparam int unsigned NR = 10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] st_q, st_d, key_q, key_d, out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, out_valid_q, busy_q;

  logic [DW-1:0] sr, mc, rk_next, round_out;
  logic [31:0]   kw0, kw1, kw2, kw3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [CW-1:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Round datapath: SubBytes+ShiftRows fused (byte 4c+r takes source column (c+r)%4), then MixColumns.
  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[DW-1-8*(4*c+r) -: 8] = SBOX[st_q[DW-1-8*(4*((c+r)%4)+r) -: 8]];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[DW-1-32*c -: 32] = mix_col(sr[DW-1-32*c -: 32]);
    end
  end

  assign kw0       = key_q[127:96] ^ sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon(cnt_q), 24'h0};
  assign kw1       = key_q[95:64] ^ kw0;
  assign kw2       = key_q[63:32] ^ kw1;
  assign kw3       = key_q[31:0]  ^ kw2;
  assign rk_next   = {kw0, kw1, kw2, kw3};
  assign round_out = ((cnt_q == CW'(NR)) ? sr : mc) ^ rk_next;

  // Next-state and datapath register control.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          st_d    = in_data ^ in_key;
          key_d   = in_key;
          cnt_d   = CW'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (cnt_q == '0 || cnt_q > CW'(NR)) begin
          state_d = IDLE;
        end else begin
          st_d  = round_out;
          key_d = rk_next;
          if (cnt_q == CW'(NR)) begin
            out_d   = round_out;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      st_q        <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_aes_encr_seq.sv
// Testbench for aes_encr_seq: FIPS-197 vectors plus random blocks against an array-based AES model
// whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_encr_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [7:0] sbox_t [256];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_encr_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic sbox_init();
    logic [7:0] v, inv;
    for (int i = 0; i < 256; i++) begin
      v   = 8'(i);
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(v, 8'(c)) == 8'h01) inv = 8'(c);
      end
      sbox_t[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Textbook AES-128: full key schedule up front, byte-array state s[r + 4c].
  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int i = 0; i < 4; i++)  w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = sbox_t[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full transaction; called at a negedge, returns at the negedge after the handshake edge.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp,
                           input int hold, input bit gap_chk);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 128'(in_ready), 128'(1));
    in_valid  = 1'b1;
    in_data   = pt;
    in_key    = key;
    out_ready = (hold == 0);
    @(negedge clk);
    if (gap_chk) chk("accept_gap", 128'(cyc - last_acc), 128'(12));
    last_acc = cyc;
    n = 0;
    while (!out_valid && n < 20) begin
      chk("round_in_ready", 128'(in_ready), 128'(0));
      chk("round_busy", 128'(busy), 128'(1));
      in_valid = 1'($urandom);
      in_data  = rnd128();
      in_key   = rnd128();
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 128'(n), 128'(10));
    chk("ciphertext", out_data, exp);
    chk("done_busy", 128'(busy), 128'(1));
    chk("done_in_ready", 128'(in_ready), 128'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_data", out_data, exp);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_out_valid", 128'(out_valid), 128'(0));
    chk("hs_busy", 128'(busy), 128'(0));
    chk("hs_in_ready", 128'(in_ready), 128'(1));
    chk("hs_retain", out_data, exp);
  endtask

  initial begin
    logic [127:0] pt, key;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;
    sbox_init();
    chk("model_fips_b", aes_model(PT_B, KEY_B), CT_B);
    chk("model_fips_c1", aes_model(PT_C, KEY_C), CT_C);

    #3;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    repeat (2) @(negedge clk);
    chk("rst_hold_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b1;
    #1 chk("rel_before_edge", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("rel_in_ready", 128'(in_ready), 128'(1));

    run_block(PT_B, KEY_B, CT_B, 0, 1'b0);
    run_block(PT_C, KEY_C, CT_C, 7, 1'b0);

    // Abort at round 5 with an asynchronous reset.
    in_valid = 1'b1;
    in_data  = PT_B;
    in_key   = KEY_B;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", 128'(busy), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("abort_in_ready", 128'(in_ready), 128'(0));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_out_data", out_data, 128'(0));
    @(negedge clk);
    chk("abort_hold_valid", 128'(out_valid), 128'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rel_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 128'(out_valid), 128'(0));
    end
    run_block(PT_C, KEY_C, CT_C, 0, 1'b0);

    // Back-to-back with in_valid/out_ready held high.
    for (int i = 0; i < 3; i++) begin
      pt  = rnd128();
      key = rnd128();
      run_block(pt, key, aes_model(pt, key), 0, i > 0);
    end

    // Random blocks with random backpressure.
    for (int i = 0; i < 6; i++) begin
      pt  = rnd128();
      key = rnd128();
      run_block(pt, key, aes_model(pt, key), int'($urandom_range(0, 3)), 1'b0);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_encr_seq.md
AES_ENCR_SEQ -- requirements
Module: aes_encr_seq

Interface
REQ-001 The block SHALL have no parameters; AES-128 only, 10 rounds fixed.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset; 0 resets the block immediately.
REQ-005 in_valid  input  1  plaintext/key offered this cycle.
REQ-006 in_ready  output  1  block can accept a new plaintext/key.
REQ-007 in_data  input  128  plaintext; byte [127:120] = state[0][0], [119:112] = state[1][0], column-major (FIPS-197 order).
REQ-008 in_key  input  128  cipher key; same byte order as in_data.
REQ-009 out_valid  output  1  ciphertext available.
REQ-010 out_ready  input  1  consumer accepts ciphertext this cycle.
REQ-011 out_data  output  128  ciphertext; same byte order as in_data.
REQ-012 busy  output  1  high in ROUND and DONE states.

Function
REQ-013 The FSM SHALL have 3 states: IDLE, ROUND, DONE; encoding is free.
REQ-014 In IDLE: in_ready=1, out_valid=0, busy=0.
REQ-015 On an edge with in_valid=1 and in_ready=1 (acceptance), the block SHALL:
- register state = in_data XOR in_key, round key = in_key, round counter = 1;
- go to ROUND.
REQ-016 After acceptance, in_data and in_key SHALL be ignored until the next acceptance.
REQ-017 Each ROUND edge SHALL apply one round to the state: SubBytes, ShiftRows, MixColumns, AddRoundKey.
REQ-018 The round key SHALL be expanded on the fly in the same edge:
- next key word0 = prev word0 XOR SubWord(RotWord(prev word3)) XOR {rcon,24'h0};
- words 1..3 chained XOR as in FIPS-197.
REQ-019 rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-020 Round 10 SHALL omit MixColumns; on that edge, register out_data, increment nothing further, go to DONE.
REQ-021 Latency: out_valid SHALL rise exactly 10 clk edges after the acceptance edge.
REQ-022 While in ROUND: in_ready=0 and busy=1; in_valid is ignored.
REQ-023 In DONE: out_valid=1 and busy=1.
REQ-024 out_data SHALL stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-025 On an edge in DONE with out_ready=1, the block SHALL go to IDLE, and out_valid SHALL fall on that edge.
REQ-026 out_data SHALL retain the last ciphertext after the handshake, until the next round-10 edge or reset.
REQ-027 in_ready=0 in DONE; the block does not accept in the handshake cycle, so minimum block period = 12 cycles.
REQ-028 out_ready while in IDLE or ROUND SHALL have no effect.
REQ-029 Round counter width SHALL be 4 bits; values 11-15 are unreachable and SHALL force IDLE if ever decoded.
REQ-030 The S-box SHALL be combinational; 20 instances are required (16 state + 4 key).
REQ-031 All outputs SHALL be glitch-free registered or state-decoded.

Reset
REQ-032 While rst=0, regardless of clk: state=IDLE; in_ready=0; out_valid=0; busy=0; out_data=0; state/key/counter registers=0.
REQ-033 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-034 rst asserted mid-ROUND or in DONE SHALL abort the operation with no out_valid pulse; the block then behaves as after power-up.

Verification
REQ-035 Encrypt the FIPS-197 Appendix B vector:
- stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734;
- response: out_data 3925841d02dc09fbdc118597196a0b32, 10 edges after acceptance.
REQ-036 Encrypt the FIPS-197 C.1 vector:
- stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff;
- response: out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 Backpressure: hold out_ready=0 for 7 cycles in DONE -> out_valid stays 1, out_data constant, in_ready stays 0; handshake on cycle 8 -> IDLE next cycle.
REQ-038 Change in_data/in_key and pulse in_valid during ROUND -> no acceptance; ciphertext matches the originally accepted inputs.
REQ-039 Assert rst at round 5 -> all outputs 0 immediately; after release, the C.1 vector yields the correct ciphertext.
REQ-040 Back-to-back operation: 3 blocks with in_valid and out_ready held 1 -> acceptances spaced 12 cycles apart, each ciphertext correct; random vectors checked against a software model.
